// File: rtl/apu_pkg.sv
// Shared constants and state types for the APU host-UART front end.
package apu_pkg;

    localparam int unsigned NUM_REGS = 24;
    localparam int unsigned ADDR_W   = 6;

    // Register indices, offsets from $4000
    localparam logic [ADDR_W-1:0] SQ1_VOL   = 6'd0;
    localparam logic [ADDR_W-1:0] SQ1_SWEEP = 6'd1;
    localparam logic [ADDR_W-1:0] SQ1_LO    = 6'd2;
    localparam logic [ADDR_W-1:0] SQ1_HI    = 6'd3;
    localparam logic [ADDR_W-1:0] SQ2_VOL   = 6'd4;
    localparam logic [ADDR_W-1:0] SQ2_SWEEP = 6'd5;
    localparam logic [ADDR_W-1:0] SQ2_LO    = 6'd6;
    localparam logic [ADDR_W-1:0] SQ2_HI    = 6'd7;
    localparam logic [ADDR_W-1:0] TRI_LINEAR = 6'd8;
    localparam logic [ADDR_W-1:0] TRI_UNUSED = 6'd9;
    localparam logic [ADDR_W-1:0] TRI_LO    = 6'd10;
    localparam logic [ADDR_W-1:0] TRI_HI    = 6'd11;
    localparam logic [ADDR_W-1:0] NOI_VOL   = 6'd12;
    localparam logic [ADDR_W-1:0] NOI_UNUSED = 6'd13;
    localparam logic [ADDR_W-1:0] NOI_LO    = 6'd14;
    localparam logic [ADDR_W-1:0] NOI_HI    = 6'd15;
    localparam logic [ADDR_W-1:0] DMC_FREQ  = 6'd16;
    localparam logic [ADDR_W-1:0] DMC_RAW   = 6'd17;
    localparam logic [ADDR_W-1:0] DMC_START = 6'd18;
    localparam logic [ADDR_W-1:0] DMC_LEN   = 6'd19;
    localparam logic [ADDR_W-1:0] STATUS    = 6'd21;
    localparam logic [ADDR_W-1:0] FRAME     = 6'd23;

    typedef enum logic [2:0] {
        RX_ARM,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic {
        WAIT_DATA,
        HAVE_DATA
    } dec_state_e;

endpackage

// File: rtl/apu_uart_decoder_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, arm-after-idle guard, centre sampling.
module uart_rx #(
    parameter int unsigned CLK_HZ = 12_000_000,
    parameter int unsigned BAUD   = 9_600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);
    import apu_pkg::*;

    localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             rx_meta;
    logic             rx_sync;
    rx_state_e        state;
    rx_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             valid_next;
    logic             ferr_next;
    logic [7:0]       byte_next;

    // Synchronizer resets to the idle level so reset release looks like a quiet line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_ARM;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shreg     <= shreg_next;
            rx_valid  <= valid_next;
            rx_byte   <= byte_next;
            frame_err <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        byte_next    = rx_byte;

        case (state)
            RX_ARM: begin
                if (!rx_sync) begin
                    cnt_next = '0;
                end else if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                end
            end
            RX_IDLE: begin
                cnt_next = '0;
                if (!rx_sync) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next     = '0;
                    shreg_next   = {rx_sync, shreg[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        valid_next = 1'b1;
                        byte_next  = shreg;
                        state_next = RX_IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = RX_ARM;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = RX_ARM;
            end
        endcase
    end

endmodule

// File: rtl/apu_uart_decoder.sv
// Host UART front end of the APU: pairs data/address bytes into register writes.
module apu_uart_decoder #(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter int unsigned BAUD        = 9_600,
    parameter int unsigned NUM_REGS    = apu_pkg::NUM_REGS,
    parameter int unsigned TIMEOUT_CYC = 24_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       seq_err,
    output logic       range_err
);
    import apu_pkg::*;

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC);

    dec_state_e         state;
    dec_state_e         state_next;
    logic [6:0]         held;
    logic [6:0]         held_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic               wr_en_next;
    logic [ADDR_W-1:0]  wr_addr_next;
    logic [7:0]         wr_data_next;
    logic               seq_err_next;
    logic               range_err_next;
    logic [ADDR_W-1:0]  idx;
    logic               idx_ok;
    logic               is_addr;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    assign is_addr = rx_byte[7];
    assign idx     = rx_byte[6:1];
    assign idx_ok  = 32'(idx) < NUM_REGS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_DATA;
            held      <= '0;
            timer     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            seq_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_next;
            held      <= held_next;
            timer     <= timer_next;
            wr_en     <= wr_en_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
            seq_err   <= seq_err_next;
            range_err <= range_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        held_next      = held;
        timer_next     = (timer == TIMER_LAST) ? timer : timer + TIMER_W'(1);
        wr_en_next     = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        seq_err_next   = 1'b0;
        range_err_next = 1'b0;

        case (state)
            WAIT_DATA: begin
                timer_next = '0;
                if (rx_valid) begin
                    if (is_addr) begin
                        seq_err_next = 1'b1;
                    end else begin
                        held_next  = rx_byte[6:0];
                        state_next = HAVE_DATA;
                    end
                end
            end
            HAVE_DATA: begin
                // An arriving byte takes priority over a timeout on the same cycle
                if (rx_valid) begin
                    timer_next = '0;
                    if (is_addr) begin
                        state_next = WAIT_DATA;
                        if (idx_ok) begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = idx;
                            wr_data_next = {rx_byte[0], held};
                        end else begin
                            range_err_next = 1'b1;
                        end
                    end else begin
                        seq_err_next = 1'b1;
                        held_next    = rx_byte[6:0];
                    end
                end else if (timer == TIMER_LAST) begin
                    seq_err_next = 1'b1;
                    held_next    = '0;
                    timer_next   = '0;
                    state_next   = WAIT_DATA;
                end
            end
            default: begin
                timer_next = '0;
                state_next = WAIT_DATA;
            end
        endcase
    end

endmodule

// File: tb/tb_apu_uart_decoder.sv
// Bench for apu_uart_decoder: serial byte stimulus, event monitor, pairing reference model.
module tb_apu_uart_decoder;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned BAUD        = 62_500;
    localparam int unsigned NUM_REGS    = 24;
    localparam int unsigned TIMEOUT_CYC = 400;
    localparam int unsigned BIT_CYC     = CLK_HZ / BAUD;
    localparam int unsigned CLK_T       = 10;
    localparam int unsigned BIT_T       = BIT_CYC * CLK_T;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       seq_err;
    logic       range_err;

    always #5 clk = ~clk;

    apu_uart_decoder #(
        .CLK_HZ      (CLK_HZ),
        .BAUD        (BAUD),
        .NUM_REGS    (NUM_REGS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .seq_err   (seq_err),
        .range_err (range_err)
    );

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_rec_t;

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  a;
        int unsigned n_wr;
        logic [5:0]  addr;
        logic [7:0]  data;
        int unsigned n_seq;
        int unsigned n_range;
    } vec_t;

    wr_rec_t     wq[$];
    wr_rec_t     eq[$];
    int unsigned seq_cnt   = 0;
    int unsigned range_cnt = 0;
    int unsigned frame_cnt = 0;
    int unsigned valid_cnt = 0;
    int unsigned lat_bad   = 0;
    logic        prev_valid = 1'b0;
    int          checks    = 0;
    int          failures  = 0;

    // Reference pairing model state
    bit          m_have;
    logic [6:0]  m_held;
    int unsigned m_seq;
    int unsigned m_range;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (wr_en) begin
                wq.push_back('{wr_addr, wr_data});
                if (!prev_valid) lat_bad++;
            end
            if (seq_err)   seq_cnt++;
            if (range_err) range_cnt++;
            if (frame_err) frame_cnt++;
            if (rx_valid)  valid_cnt++;
            prev_valid = rx_valid;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_T);
        end
        rx = stop_bit;
        #(BIT_T);
        rx = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic compare_writes(input string name);
        wr_rec_t a;
        wr_rec_t e;
        check({name, "_wr_count"}, wq.size(), eq.size());
        while (wq.size() > 0 && eq.size() > 0) begin
            a = wq.pop_front();
            e = eq.pop_front();
            check({name, "_wr_addr"}, 32'(a.addr), 32'(e.addr));
            check({name, "_wr_data"}, 32'(a.data), 32'(e.data));
        end
        wq.delete();
        eq.delete();
    endtask

    // Pairing rules applied byte by byte (no timeouts: random gaps stay short)
    task automatic model_byte(input logic [7:0] b);
        int unsigned ix;
        if (b[7] == 1'b0) begin
            if (m_have) m_seq++;
            m_have = 1'b1;
            m_held = b[6:0];
        end else if (!m_have) begin
            m_seq++;
        end else begin
            ix = (int'(b) / 2) % 64;
            if (ix < NUM_REGS) eq.push_back('{6'(ix), {b[0], m_held}});
            else m_range++;
            m_have = 1'b0;
        end
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        int unsigned s_seq;
        int unsigned s_rng;
        int unsigned s_frm;
        int unsigned s_val;
        logic [5:0]  last_addr;
        logic [7:0]  last_data;
        logic [7:0]  b;
        logic [7:0]  last_b;

        vecs[0] = '{8'h3F, 8'h81, 1, 6'h00, 8'hBF, 0, 0};
        vecs[1] = '{8'h01, 8'h86, 1, 6'h03, 8'h01, 0, 0};
        vecs[2] = '{8'h0B, 8'h95, 1, 6'h0A, 8'h8B, 0, 0};
        vecs[3] = '{8'h05, 8'h9D, 1, 6'h0E, 8'h85, 0, 0};
        vecs[4] = '{8'h7F, 8'hAF, 1, 6'h17, 8'hFF, 0, 0};
        vecs[5] = '{8'h00, 8'hB0, 0, 6'h00, 8'h00, 0, 1};
        vecs[6] = '{8'h2A, 8'hB1, 0, 6'h00, 8'h00, 0, 1};
        vecs[7] = '{8'h55, 8'hAE, 1, 6'h17, 8'h55, 0, 0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs",
              32'({wr_en, wr_addr, wr_data, rx_valid, rx_byte, frame_err, seq_err, range_err}), 32'd0);
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("post_reset_outputs",
              32'({wr_en, wr_addr, wr_data, rx_valid, frame_err, seq_err, range_err}), 32'd0);

        last_addr = '0;
        last_data = '0;
        for (int i = 0; i < 8; i++) begin
            s_seq = seq_cnt;
            s_rng = range_cnt;
            s_frm = frame_cnt;
            send_byte(vecs[i].d, 1'b1);
            send_byte(vecs[i].a, 1'b1);
            #(BIT_T);
            if (vecs[i].n_wr == 1) begin
                eq.push_back('{vecs[i].addr, vecs[i].data});
                last_addr = vecs[i].addr;
                last_data = vecs[i].data;
            end
            compare_writes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_seq_err", i), seq_cnt - s_seq, vecs[i].n_seq);
            check($sformatf("vec%0d_range_err", i), range_cnt - s_rng, vecs[i].n_range);
            check($sformatf("vec%0d_frame_err", i), frame_cnt - s_frm, 0);
            check($sformatf("vec%0d_rx_byte", i), 32'(rx_byte), 32'(vecs[i].a));
            check($sformatf("vec%0d_hold_addr", i), 32'(wr_addr), 32'(last_addr));
            check($sformatf("vec%0d_hold_data", i), 32'(wr_data), 32'(last_data));
        end

        // Orphan address after reset, then data overwrite before a valid address
        apply_reset();
        s_seq = seq_cnt;
        send_byte(8'h84, 1'b1);
        #(BIT_T);
        compare_writes("orphan");
        check("orphan_seq_err", seq_cnt - s_seq, 1);
        s_seq = seq_cnt;
        send_byte(8'h08, 1'b1);
        send_byte(8'h17, 1'b1);
        send_byte(8'h84, 1'b1);
        #(BIT_T);
        eq.push_back('{6'h02, 8'h17});
        compare_writes("last_data_wins");
        check("last_data_wins_seq_err", seq_cnt - s_seq, 1);

        // Framing error, one idle bit, then a clean pair
        s_frm = frame_cnt;
        s_val = valid_cnt;
        send_byte(8'h40, 1'b0);
        check("bad_stop_frame_err", frame_cnt - s_frm, 1);
        check("bad_stop_no_valid", valid_cnt - s_val, 0);
        #(BIT_T);
        send_byte(8'h40, 1'b1);
        send_byte(8'h91, 1'b1);
        #(BIT_T);
        eq.push_back('{6'h08, 8'hC0});
        compare_writes("after_frame_err");
        check("after_frame_err_valid", valid_cnt - s_val, 2);

        // Timeout of a lone data byte, then the orphan address and an out-of-range pair
        s_seq = seq_cnt;
        s_rng = range_cnt;
        send_byte(8'h12, 1'b1);
        repeat (TIMEOUT_CYC - 50) @(negedge clk);
        check("timeout_not_early", seq_cnt - s_seq, 0);
        repeat (60) @(negedge clk);
        check("timeout_seq_err", seq_cnt - s_seq, 1);
        send_byte(8'h83, 1'b1);
        #(BIT_T);
        check("timeout_orphan_seq_err", seq_cnt - s_seq, 2);
        send_byte(8'h00, 1'b1);
        send_byte(8'hB0, 1'b1);
        #(BIT_T);
        check("idx18_range_err", range_cnt - s_rng, 1);
        compare_writes("timeout_range");

        // Reset mid-address-byte, released while the line is still toggling
        s_seq = seq_cnt;
        fork
            begin
                send_byte(8'h55, 1'b1);
                send_byte(8'h8A, 1'b1);
            end
            begin
                #(BIT_T * 14 + BIT_T / 2);
                rst = 1'b1;
                #(BIT_T * 2);
                rst = 1'b0;
            end
        join
        #(BIT_T * 2);
        compare_writes("reset_mid_pair");
        check("reset_mid_pair_seq_err", seq_cnt - s_seq, 0);
        send_byte(8'h30, 1'b1);
        send_byte(8'h80, 1'b1);
        #(BIT_T);
        eq.push_back('{6'h00, 8'h30});
        compare_writes("after_mid_reset");

        // Randomized byte stream against the pairing model
        apply_reset();
        m_have  = 1'b0;
        m_held  = '0;
        m_seq   = 0;
        m_range = 0;
        s_seq   = seq_cnt;
        s_rng   = range_cnt;
        last_b  = '0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 99) < 50) begin
                b = {1'b0, 7'($urandom_range(0, 127))};
            end else begin
                b = {1'b1, 6'($urandom_range(0, 31)), 1'($urandom_range(0, 1))};
            end
            send_byte(b, 1'b1);
            model_byte(b);
            last_b = b;
            #(BIT_T * $urandom_range(0, 2));
        end
        #(BIT_T);
        compare_writes("rand");
        check("rand_seq_err", seq_cnt - s_seq, m_seq);
        check("rand_range_err", range_cnt - s_rng, m_range);
        check("rand_last_rx_byte", 32'(rx_byte), 32'(last_b));

        check("wr_latency_after_valid", lat_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
